// File: rtl/timer_pkg.sv
// Shared definitions for the timer programming sequencer: register map,
// TCR/TSR bit positions, sequencer and transfer-engine state encodings.
package timer_pkg;

  localparam logic [7:0] TDR_OFS = 8'h00;
  localparam logic [7:0] TCR_OFS = 8'h01;
  localparam logic [7:0] TSR_OFS = 8'h02;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DOWN   = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  localparam logic [7:0] TCR_LOAD_VAL = 8'h01 << TCR_LOAD;
  localparam logic [7:0] TCR_STOP_VAL = 8'h00;
  localparam logic [7:0] TSR_CLR_VAL  = 8'h00;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_TDR   = 4'd1;
  localparam logic [3:0] ST_RD_TSR   = 4'd2;
  localparam logic [3:0] ST_CLR_TSR  = 4'd3;
  localparam logic [3:0] ST_WR_LOAD  = 4'd4;
  localparam logic [3:0] ST_WR_RUN   = 4'd5;
  localparam logic [3:0] ST_WAIT_EVT = 4'd6;
  localparam logic [3:0] ST_SVC_RD   = 4'd7;
  localparam logic [3:0] ST_SVC_CLR  = 4'd8;
  localparam logic [3:0] ST_STOP_WR  = 4'd9;
  localparam logic [3:0] ST_ERR      = 4'd10;

  function automatic logic [7:0] tcr_run(input logic down, input logic [1:0] cks);
    logic [7:0] v;
    v = 8'h00;
    v[TCR_EN] = 1'b1;
    v[TCR_DOWN] = down;
    v[TCR_CKS_HI:TCR_CKS_LO] = cks;
    return v;
  endfunction

  function automatic logic is_xfer(input logic [3:0] st);
    logic r;
    case (st)
      ST_WR_TDR, ST_RD_TSR, ST_CLR_TSR, ST_WR_LOAD, ST_WR_RUN,
      ST_SVC_RD, ST_SVC_CLR, ST_STOP_WR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_ctrl_seq_if.sv
// APB bus bundle between the timer sequencer (master) and the timer block.
interface timer_ctrl_seq_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/timer_ctrl_seq_apb_master_if.sv
// Single APB transfer engine: takes one request, runs SETUP/ACCESS, reports
// done with fail on pslverr or after APB_TO ACCESS cycles without pready.
module apb_master_if
  import timer_pkg::*;
#(
  parameter int APB_TO = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic       fail,
  output logic [7:0] rdata,
  timer_ctrl_seq_if.master apb
);
  localparam int TW = $clog2(APB_TO + 1);

  apb_state_e    st_r;
  logic [TW-1:0] wait_r;
  logic          psel_r, penable_r, pwrite_r, done_r, fail_r;
  logic [7:0]    paddr_r, pwdata_r, rdata_r;

  assign apb.psel    = psel_r;
  assign apb.penable = penable_r;
  assign apb.pwrite  = pwrite_r;
  assign apb.paddr   = paddr_r;
  assign apb.pwdata  = pwdata_r;
  assign done        = done_r;
  assign fail        = fail_r;
  assign rdata       = rdata_r;

  // Transfer engine; a request is not re-accepted in the cycle done is
  // shown, so the sequencer has exactly one cycle to move on.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      st_r      <= APB_IDLE;
      wait_r    <= '0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= 8'h00;
      pwdata_r  <= 8'h00;
      rdata_r   <= 8'h00;
      done_r    <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      fail_r <= 1'b0;
      case (st_r)
        APB_IDLE: begin
          if (req && !done_r) begin
            st_r      <= APB_SETUP;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            pwrite_r  <= wr;
            paddr_r   <= addr;
            pwdata_r  <= wdata;
          end
        end
        APB_SETUP: begin
          st_r      <= APB_ACCESS;
          penable_r <= 1'b1;
          wait_r    <= '0;
        end
        APB_ACCESS: begin
          if (apb.pready) begin
            st_r      <= APB_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            done_r    <= 1'b1;
            fail_r    <= apb.pslverr;
            rdata_r   <= apb.prdata;
          end else if (wait_r == TW'(APB_TO - 1)) begin
            st_r      <= APB_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            done_r    <= 1'b1;
            fail_r    <= 1'b1;
          end else begin
            wait_r <= wait_r + TW'(1);
          end
        end
        default: begin
          st_r      <= APB_IDLE;
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/timer_ctrl_seq.sv
// Timer programming/servicing sequencer over APB.
// Build option: define TIMER_CTRL_AUTO_RELOAD_EN to re-arm the timer after each event.
module timer_ctrl_seq
  import timer_pkg::*;
#(
  parameter logic [7:0] TMR_BASE = 8'h00,
  parameter int         APB_TO   = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cfg_tdr,
  input  logic       cfg_down,
  input  logic [1:0] cfg_cks,
  input  logic       tmr_irq,
  timer_ctrl_seq_if.master apb,
  output logic       busy,
  output logic       evt_valid,
  output logic       evt_ovf,
  output logic       evt_udf,
  output logic [7:0] evt_cnt,
  output logic       err
);
  logic [3:0] state_r, next_s, seq_next_s;
  logic       req_s, wr_s, done_s, fail_s;
  logic [7:0] addr_s, wdata_s, rdata_s;
  logic [7:0] tdr_r;
  logic       down_r, reload_r, stop_r, ovf_lat_r, udf_lat_r;
  logic [1:0] cks_r;
  logic       busy_r, evt_valid_r, evt_ovf_r, evt_udf_r, err_r;
  logic [7:0] evt_cnt_r;
  logic       stop_pend_s, start_acc_s;

  assign busy      = busy_r;
  assign evt_valid = evt_valid_r;
  assign evt_ovf   = evt_ovf_r;
  assign evt_udf   = evt_udf_r;
  assign evt_cnt   = evt_cnt_r;
  assign err       = err_r;

  assign stop_pend_s = stop_r | stop;
  assign start_acc_s = start & (((state_r == ST_IDLE) & ~stop) | (state_r == ST_ERR));

  apb_master_if #(.APB_TO(APB_TO)) u_apb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (req_s),
    .wr      (wr_s),
    .addr    (addr_s),
    .wdata   (wdata_s),
    .done    (done_s),
    .fail    (fail_s),
    .rdata   (rdata_s),
    .apb     (apb)
  );

  // Transfer request implied by the current sequencer state.
  always_comb begin
    req_s   = 1'b1;
    wr_s    = 1'b1;
    addr_s  = TMR_BASE + TCR_OFS;
    wdata_s = 8'h00;
    case (state_r)
      ST_WR_TDR: begin
        addr_s  = TMR_BASE + TDR_OFS;
        wdata_s = tdr_r;
      end
      ST_RD_TSR, ST_SVC_RD: begin
        wr_s   = 1'b0;
        addr_s = TMR_BASE + TSR_OFS;
      end
      ST_CLR_TSR, ST_SVC_CLR: begin
        addr_s  = TMR_BASE + TSR_OFS;
        wdata_s = TSR_CLR_VAL;
      end
      ST_WR_LOAD: wdata_s = TCR_LOAD_VAL;
      ST_WR_RUN:  wdata_s = tcr_run(down_r, cks_r);
      ST_STOP_WR: wdata_s = TCR_STOP_VAL;
      default:    req_s   = 1'b0;
    endcase
  end

  // Successor of each transfer state when it completes cleanly.
  always_comb begin
    seq_next_s = ST_IDLE;
    case (state_r)
      ST_WR_TDR:  seq_next_s = reload_r ? ST_WR_LOAD : ST_RD_TSR;
      ST_RD_TSR:  seq_next_s = (rdata_s == 8'h00) ? ST_WR_LOAD : ST_CLR_TSR;
      ST_CLR_TSR: seq_next_s = ST_WR_LOAD;
      ST_WR_LOAD: seq_next_s = ST_WR_RUN;
      ST_WR_RUN:  seq_next_s = ST_WAIT_EVT;
      ST_SVC_RD:  seq_next_s = (rdata_s == 8'h00) ? ST_WAIT_EVT : ST_SVC_CLR;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
      ST_SVC_CLR: seq_next_s = ST_WR_TDR;
`else
      ST_SVC_CLR: seq_next_s = ST_STOP_WR;
`endif
      default:    seq_next_s = ST_IDLE;
    endcase
  end

  // Sequencer next state; a pending stop only takes effect at a transfer boundary.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:     next_s = stop ? ST_STOP_WR : (start ? ST_WR_TDR : ST_IDLE);
      ST_ERR:      next_s = start ? ST_WR_TDR : ST_ERR;
      ST_WAIT_EVT: next_s = stop ? ST_STOP_WR : (tmr_irq ? ST_SVC_RD : ST_WAIT_EVT);
      ST_WR_TDR, ST_RD_TSR, ST_CLR_TSR, ST_WR_LOAD, ST_WR_RUN,
      ST_SVC_RD, ST_SVC_CLR, ST_STOP_WR: begin
        if (!done_s)                    next_s = state_r;
        else if (fail_s)                next_s = ST_ERR;
        else if (state_r == ST_STOP_WR) next_s = ST_IDLE;
        else if (stop_pend_s)           next_s = ST_STOP_WR;
        else                            next_s = seq_next_s;
      end
      default:     next_s = ST_IDLE;
    endcase
  end

  // State, shadow configuration, event reporting and sticky error.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      stop_r      <= 1'b0;
      tdr_r       <= 8'h00;
      down_r      <= 1'b0;
      cks_r       <= 2'b00;
      reload_r    <= 1'b0;
      ovf_lat_r   <= 1'b0;
      udf_lat_r   <= 1'b0;
      evt_valid_r <= 1'b0;
      evt_ovf_r   <= 1'b0;
      evt_udf_r   <= 1'b0;
      evt_cnt_r   <= 8'h00;
      err_r       <= 1'b0;
    end else begin
      state_r     <= next_s;
      busy_r      <= (next_s != ST_IDLE) && (next_s != ST_ERR);
      stop_r      <= (stop_r | (stop & is_xfer(state_r))) & is_xfer(next_s)
                     & (next_s != ST_STOP_WR);
      evt_valid_r <= 1'b0;
      if (start_acc_s) begin
        tdr_r     <= cfg_tdr;
        down_r    <= cfg_down;
        cks_r     <= cfg_cks;
        reload_r  <= 1'b0;
        evt_cnt_r <= 8'h00;
        err_r     <= 1'b0;
      end
      if (done_s && fail_s) begin
        err_r <= 1'b1;
      end
      if (done_s && !fail_s && (state_r == ST_SVC_RD) && (rdata_s != 8'h00)) begin
        ovf_lat_r <= rdata_s[TSR_OVF];
        udf_lat_r <= rdata_s[TSR_UDF];
      end
      if (done_s && !fail_s && (state_r == ST_SVC_CLR)) begin
        evt_valid_r <= 1'b1;
        evt_cnt_r   <= evt_cnt_r + 8'h01;
        evt_ovf_r   <= ovf_lat_r;
        evt_udf_r   <= udf_lat_r;
        reload_r    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_timer_ctrl_seq.sv
// Directed bench for timer_ctrl_seq with a small APB timer-register model.
module tb_timer_ctrl_seq;
  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_tdr = 8'h00;
  logic       cfg_down = 1'b0;
  logic [1:0] cfg_cks = 2'b00;
  logic       tmr_irq;
  logic       busy, evt_valid, evt_ovf, evt_udf, err;
  logic [7:0] evt_cnt;

  timer_ctrl_seq_if apb();

  timer_ctrl_seq #(.TMR_BASE(8'h00), .APB_TO(16)) dut (
    .pclk(pclk), .presetn(presetn), .start(start), .stop(stop),
    .cfg_tdr(cfg_tdr), .cfg_down(cfg_down), .cfg_cks(cfg_cks), .tmr_irq(tmr_irq),
    .apb(apb), .busy(busy), .evt_valid(evt_valid), .evt_ovf(evt_ovf),
    .evt_udf(evt_udf), .evt_cnt(evt_cnt), .err(err)
  );

  always #5 pclk = ~pclk;

  // Timer register model
  logic [7:0]  tsr_m = 8'h00;
  logic [7:0]  tsr_set_val = 8'h00;
  logic        tsr_set_req = 1'b0;
  int          delay = 0;
  logic        hang_load = 1'b0;
  logic        slverr_tdr = 1'b0;
  logic        irq_force = 1'b0;
  int          acc_cnt = 0;
  logic [16:0] wlog[$];
  logic [7:0]  rlast = 8'h00;
  int          rcnt = 0;
  int          evt_hi = 0;
  int          hung = 0;
  logic        hang_hit;

  assign hang_hit    = hang_load && (apb.paddr == 8'h01) && (apb.pwdata == 8'h80);
  assign apb.pready  = apb.psel && apb.penable && (acc_cnt >= delay) && !hang_hit;
  assign apb.prdata  = (apb.paddr == 8'h02) ? tsr_m : 8'h00;
  assign apb.pslverr = slverr_tdr && (apb.paddr == 8'h00);
  assign tmr_irq     = (tsr_m != 8'h00) || irq_force;

  always @(posedge pclk) begin
    if (apb.psel && apb.penable) begin
      if (apb.pready) begin
        acc_cnt <= 0;
        if (apb.pwrite) begin
          wlog.push_back({1'b1, apb.paddr, apb.pwdata});
        end else begin
          rlast <= apb.prdata;
          rcnt  <= rcnt + 1;
        end
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
      if (hang_hit) hung <= hung + 1;
    end else begin
      acc_cnt <= 0;
    end
    if (tsr_set_req) tsr_m <= tsr_set_val;
    else if (apb.psel && apb.penable && apb.pready && apb.pwrite && apb.paddr == 8'h02)
      tsr_m <= apb.pwdata;
    if (evt_valid) evt_hi <= evt_hi + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  function automatic logic [16:0] wl(input int i);
    if (i >= 0 && i < wlog.size()) return wlog[i];
    return 17'h1FFFF;
  endfunction

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic set_tsr(input logic [7:0] v);
    tsr_set_val = v; tsr_set_req = 1'b1; step(1); tsr_set_req = 1'b0;
  endtask

  task automatic wait_wr(input int n, input string tag);
    int k = 0;
    while (wlog.size() < n && k < 300) begin step(1); k++; end
    chk(tag, 32'(wlog.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin step(1); k++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_evt(input int n, input string tag);
    int k = 0;
    while (evt_hi < n && k < 300) begin step(1); k++; end
    chk(tag, 32'(evt_hi), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int m, e0, r0, k;
    step(3);
    chk("rst_psel", 32'(apb.psel), 32'd0);
    chk("rst_penable", 32'(apb.penable), 32'd0);
    chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
    chk("rst_paddr", 32'(apb.paddr), 32'h00);
    chk("rst_pwdata", 32'(apb.pwdata), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evt", 32'({evt_valid, evt_ovf, evt_udf}), 32'd0);
    chk("rst_cnt", 32'(evt_cnt), 32'h00);
    chk("rst_err", 32'(err), 32'd0);
    presetn = 1'b1;
    step(1);

    // Programming with TSR clear: no TSR write
    cfg_tdr = 8'hFF; cfg_down = 1'b1; cfg_cks = 2'b00;
    m = wlog.size();
    pulse_start();
    wait_wr(m + 3, "prog_to");
    step(10);
    chk("prog_n", 32'(wlog.size()), 32'(m + 3));
    chk("prog_w0", 32'(wl(m)), 32'h100FF);
    chk("prog_w1", 32'(wl(m + 1)), 32'h10180);
    chk("prog_w2", 32'(wl(m + 2)), 32'h10130);
    chk("prog_rd", 32'(rcnt), 32'd1);
    chk("prog_busy", 32'(busy), 32'd1);
    chk("prog_psel", 32'(apb.psel), 32'd0);

    // Underflow event
    m = wlog.size();
    set_tsr(8'h02);
    wait_evt(1, "evt1_to");
    step(1);
    chk("evt1_pulse", 32'(evt_valid), 32'd0);
    chk("evt1_udf", 32'(evt_udf), 32'd1);
    chk("evt1_ovf", 32'(evt_ovf), 32'd0);
    chk("evt1_cnt", 32'(evt_cnt), 32'h01);
    chk("evt1_rd", 32'(rlast), 32'h02);
    chk("evt1_clr", 32'(wl(m)), 32'h10200);
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    wait_wr(m + 4, "reload_to");
    step(10);
    chk("reload_n", 32'(wlog.size()), 32'(m + 4));
    chk("reload_w0", 32'(wl(m + 1)), 32'h100FF);
    chk("reload_w1", 32'(wl(m + 2)), 32'h10180);
    chk("reload_w2", 32'(wl(m + 3)), 32'h10130);
    chk("reload_busy", 32'(busy), 32'd1);
    set_tsr(8'h02);
    wait_evt(2, "evt2_to");
    step(20);
    chk("evt2_cnt", 32'(evt_cnt), 32'h02);
    chk("evt2_hi", 32'(evt_hi), 32'd2);
    pulse_stop();
    wait_idle("evt2_idle");
    chk("evt2_stop", 32'(wl(wlog.size() - 1)), 32'h10100);
`else
    wait_idle("single_idle");
    chk("single_n", 32'(wlog.size()), 32'(m + 2));
    chk("single_stop", 32'(wl(m + 1)), 32'h10100);
    set_tsr(8'h02);
    step(20);
    chk("single_hi", 32'(evt_hi), 32'd1);
    chk("single_cnt", 32'(evt_cnt), 32'h01);
    chk("single_busy", 32'(busy), 32'd0);
`endif
    set_tsr(8'h00);

    // TSR pending at start gets cleared; irq during programming is deferred
    set_tsr(8'h02);
    cfg_tdr = 8'h5A; cfg_down = 1'b0; cfg_cks = 2'b10;
    e0 = evt_hi;
    m = wlog.size();
    pulse_start();
    wait_wr(m + 4, "pre_to");
    step(10);
    chk("pre_n", 32'(wlog.size()), 32'(m + 4));
    chk("pre_w0", 32'(wl(m)), 32'h1005A);
    chk("pre_w1", 32'(wl(m + 1)), 32'h10200);
    chk("pre_w2", 32'(wl(m + 2)), 32'h10180);
    chk("pre_w3", 32'(wl(m + 3)), 32'h10112);
    chk("pre_cnt", 32'(evt_cnt), 32'h00);

    // Spurious irq: TSR read returns 0
    r0 = rcnt;
    irq_force = 1'b1; step(1); irq_force = 1'b0;
    step(15);
    chk("spur_rd", 32'(rcnt), 32'(r0 + 1));
    chk("spur_hi", 32'(evt_hi), 32'(e0));
    chk("spur_n", 32'(wlog.size()), 32'(m + 4));
    chk("spur_busy", 32'(busy), 32'd1);
    pulse_stop();
    wait_idle("wstop_idle");
    chk("wstop_w", 32'(wl(m + 4)), 32'h10100);

    // Stop during an extended ACCESS of WR_TDR
    delay = 3;
    m = wlog.size();
    pulse_start();
    k = 0;
    while (!(apb.psel && apb.penable) && k < 50) begin step(1); k++; end
    chk("dstop_acc", 32'(apb.psel && apb.penable), 32'd1);
    pulse_stop();
    wait_idle("dstop_idle");
    chk("dstop_n", 32'(wlog.size()), 32'(m + 2));
    chk("dstop_w0", 32'(wl(m)), 32'h1005A);
    chk("dstop_w1", 32'(wl(m + 1)), 32'h10100);
    delay = 0;

    // pready stuck on WR_LOAD: timeout after 16 ACCESS cycles
    hang_load = 1'b1;
    m = wlog.size();
    pulse_start();
    k = 0;
    while (!err && k < 300) begin step(1); k++; end
    chk("to_err", 32'(err), 32'd1);
    chk("to_cycles", 32'(hung), 32'd16);
    chk("to_psel", 32'(apb.psel), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_n", 32'(wlog.size()), 32'(m + 1));
    hang_load = 1'b0;
    pulse_start();
    chk("to_clr", 32'(err), 32'd0);
    chk("to_rebusy", 32'(busy), 32'd1);
    pulse_stop();
    wait_idle("to_idle");
    chk("to_stop", 32'(wl(wlog.size() - 1)), 32'h10100);

    // start and stop together in IDLE: only the stop write
    m = wlog.size();
    r0 = rcnt;
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    wait_idle("ss_idle");
    chk("ss_n", 32'(wlog.size()), 32'(m + 1));
    chk("ss_w", 32'(wl(m)), 32'h10100);
    chk("ss_rd", 32'(rcnt), 32'(r0));

    // pslverr on the TDR write
    slverr_tdr = 1'b1;
    pulse_start();
    k = 0;
    while (!err && k < 100) begin step(1); k++; end
    chk("se_err", 32'(err), 32'd1);
    chk("se_busy", 32'(busy), 32'd0);
    slverr_tdr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
